dffram_port_arb: RTL

DFFRAM_PORT_ARB -- requirements
Module: dffram_port_arb

---
 rtl/dffram_pkg.sv | 20 ++
 rtl/dffram_rr_arb.sv | 54 +++++
 rtl/dffram_port_arb.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dffram_pkg.sv
// Shared widths, default depth and helpers for the two-port DFF-RAM arbiter.
package dffram_pkg;

    localparam int ADDRWIDTH     = 5;
    localparam int WORDWIDTH     = 8;
    localparam int DEFAULT_DEPTH = 28;

    typedef logic [ADDRWIDTH-1:0] addr_t;
    typedef logic [WORDWIDTH-1:0] word_t;

    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } req_idx_e;

    function automatic logic addr_oor(input addr_t addr, input int depth);
        return (int'(addr) >= depth);
    endfunction

endpackage

// File: rtl/dffram_rr_arb.sv
// Two-way write-port arbiter holding last_grant.
// DFFRAM_ARB_ROUND_ROBIN_EN selects round-robin conflict resolution; default is fixed priority to requester 0.
module dffram_rr_arb
    import dffram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wreq0_i,
    input  logic wreq1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    req_idx_e last_grant_q;
    req_idx_e last_grant_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (wreq0_i && wreq1_i) begin
`ifdef DFFRAM_ARB_ROUND_ROBIN_EN
            if (last_grant_q == GNT_REQ1) begin
                gnt0_o = 1'b1;
            end else begin
                gnt1_o = 1'b1;
            end
`else
            gnt0_o = 1'b1;
`endif
        end else begin
            gnt0_o = wreq0_i;
            gnt1_o = wreq1_i;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt1_o) begin
            last_grant_d = GNT_REQ1;
        end else if (gnt0_o) begin
            last_grant_d = GNT_REQ0;
        end
    end

    // Reset to requester 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_REQ1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dffram_port_arb.sv
// Two-requester front end for a DFF RAM: dedicated async read ports, one shared write port.
// Build with DFFRAM_ARB_ROUND_ROBIN_EN for round-robin write conflicts (see dffram_rr_arb).
module dffram_port_arb
    import dffram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    input  logic                 req0_we,
    input  logic [ADDRWIDTH-1:0] req0_addr,
    input  logic [WORDWIDTH-1:0] req0_wdata,
    output logic                 req0_ready,

    input  logic                 req1_valid,
    input  logic                 req1_we,
    input  logic [ADDRWIDTH-1:0] req1_addr,
    input  logic [WORDWIDTH-1:0] req1_wdata,
    output logic                 req1_ready,

    output logic                 rsp0_valid,
    output logic [WORDWIDTH-1:0] rsp0_rdata,
    output logic                 rsp0_err,

    output logic                 rsp1_valid,
    output logic [WORDWIDTH-1:0] rsp1_rdata,
    output logic                 rsp1_err,

    output logic [ADDRWIDTH-1:0] ram_raddr_a,
    output logic [ADDRWIDTH-1:0] ram_raddr_b,
    input  logic [WORDWIDTH-1:0] ram_rdata_a,
    input  logic [WORDWIDTH-1:0] ram_rdata_b,

    output logic [ADDRWIDTH-1:0] ram_waddr,
    output logic [WORDWIDTH-1:0] ram_wdata,
    output logic                 ram_we
);

    logic oor0, oor1;
    logic rd0, rd1;
    logic wr0, wr1;
    logic drop0, drop1;
    logic gnt0, gnt1;

    addr_t raddr_a_q, raddr_a_d;
    addr_t raddr_b_q, raddr_b_d;
    logic  rsp0_valid_q, rsp0_valid_d;
    logic  rsp1_valid_q, rsp1_valid_d;
    word_t rsp0_rdata_q, rsp0_rdata_d;
    word_t rsp1_rdata_q, rsp1_rdata_d;
    logic  rsp0_err_q, rsp0_err_d;
    logic  rsp1_err_q, rsp1_err_d;

    assign oor0  = addr_oor(req0_addr, DEPTH);
    assign oor1  = addr_oor(req1_addr, DEPTH);
    assign rd0   = req0_valid & ~req0_we;
    assign rd1   = req1_valid & ~req1_we;
    // Out-of-range writes never compete for the port; they are accepted and dropped.
    assign wr0   = req0_valid & req0_we & ~oor0;
    assign wr1   = req1_valid & req1_we & ~oor1;
    assign drop0 = req0_valid & req0_we & oor0;
    assign drop1 = req1_valid & req1_we & oor1;

    dffram_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .wreq0_i (wr0),
        .wreq1_i (wr1),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    assign req0_ready = rd0 | drop0 | gnt0;
    assign req1_ready = rd1 | drop1 | gnt1;

    assign ram_we    = ~rst & (gnt0 | gnt1);
    assign ram_waddr = gnt1 ? req1_addr  : req0_addr;
    assign ram_wdata = gnt1 ? req1_wdata : req0_wdata;

    always_comb begin
        raddr_a_d    = rd0 ? req0_addr : raddr_a_q;
        raddr_b_d    = rd1 ? req1_addr : raddr_b_q;

        rsp0_valid_d = rd0;
        rsp1_valid_d = rd1;
        rsp0_err_d   = rd0 & oor0;
        rsp1_err_d   = rd1 & oor1;

        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        if (rd0) begin
            rsp0_rdata_d = oor0 ? '0 : ram_rdata_a;
        end
        if (rd1) begin
            rsp1_rdata_d = oor1 ? '0 : ram_rdata_b;
        end
    end

    // Read addresses are combinational during a read so the async RAM data is ready at the edge.
    assign ram_raddr_a = rst ? '0 : raddr_a_d;
    assign ram_raddr_b = rst ? '0 : raddr_b_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_a_q    <= '0;
            raddr_b_q    <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            raddr_a_q    <= raddr_a_d;
            raddr_b_q    <= raddr_b_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_err   = rsp1_err_q;

endmodule
